apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
// APB4 completer: small word-addressed register bank with byte-strobe writes, programmable wait states and PSLVERR.
// Sits on the peripheral side of the PSEL0 select line, opposite the team's APB master, and answers its setup/access transfers.
// Provides the slave end the master needs for loopback and system tests.
// PARAMETERS
// ADDR_WIDTH   32           APB address width
// DATA_WIDTH   32           APB data width (fixed 32; PSTRB is 4 bits)
// STRB_WIDTH   DATA_WIDTH/8 byte-strobe width
// BASE_ADDR    32'h0000_0FA0  byte address of register 0 (decimal 4000, word aligned)
// NUM_REGS     4            registers at BASE_ADDR + 4*i; index NUM_REGS-1 is read-only ID
// WAIT_CYCLES  0            access-phase wait states inserted before PREADY (0..15)
// ID_VALUE     32'hA5B4_0001  constant returned by the ID register
// PORTS
// PCLK       in   1           clock, rising edge
// PRESETn    in   1           asynchronous active-low reset
// PSEL       in   1           slave select
// PENABLE    in   1           access-phase indicator
// PWRITE     in   1           1 = write, 0 = read
// PADDR      in   ADDR_WIDTH  byte address
// PWDATA     in   DATA_WIDTH  write data
// PSTRB      in   STRB_WIDTH  write byte-lane enables
// PPROT      in   3           protection; accepted and ignored
// PREADY     out  1           transfer completes in this access cycle
// PRDATA     out  DATA_WIDTH  read data, valid only while PREADY=1 and PWRITE=0
// PSLVERR    out  1           error, valid only while PREADY=1
// wr_pulse   out  1           one-cycle pulse after a successful write commits
// wr_index   out  2           register index of the last committed write
// BEHAVIOUR
// - Reset (asynchronous): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wr_pulse=0, wr_index=0, all RW registers=0.
// - FSM states: IDLE, WAIT, DONE.
//   IDLE: if PSEL & !PENABLE (setup), latch PADDR, PWRITE, PWDATA, PSTRB and load cnt=WAIT_CYCLES.
//     If WAIT_CYCLES==0, go to DONE; otherwise go to WAIT.
//   WAIT: in each cycle with PSEL & PENABLE, decrement cnt. At cnt==1, go to DONE.
//   DONE: PREADY=1 for exactly this one access cycle, then return to IDLE.
// - PREADY, PRDATA and PSLVERR are registered. They are driven high/valid in DONE and are 0 in every other state.
// - Latency: the first access cycle after setup is the PREADY cycle when WAIT_CYCLES=0. In general there are WAIT_CYCLES+1 access cycles.
// - Decode, evaluated on the latched address: offset = PADDR - BASE_ADDR; idx = offset>>2.
//   err = PADDR[1:0]!=0 | PADDR<BASE_ADDR | idx>=NUM_REGS | (write & idx==NUM_REGS-1).
// - Write commit happens at the rising edge that ends DONE when PWRITE=1 and err=0.
//   Byte lane k is updated only if PSTRB[k]=1. PSTRB=0 is legal: no change, but wr_pulse still fires.
// - A write with err=1 changes no register, and wr_pulse stays 0.
// - Read: PRDATA = reg[idx], or ID_VALUE for the ID index. A read with err=1 returns PRDATA=0 and PSLVERR=1. PSTRB is ignored on reads.
// - wr_pulse is high for the one cycle after the commit edge. wr_index holds the index until the next commit.
// - Back-to-back transfers: the master's next setup cycle coincides with IDLE after DONE, so there is no dead cycle.
// - PSEL=0 or PENABLE=0 while in WAIT is a protocol violation: go to IDLE, no commit, PREADY stays 0.
// - Setup seen while not in IDLE: ignored until IDLE is reached.
// - Reset asserted mid-transfer: immediate return to the reset values, and any pending write is dropped.
// - Address arithmetic is ADDR_WIDTH-bit unsigned. The compare with BASE_ADDR prevents wrap-around on offset.
// TESTING
// 1 Reset: hold PRESETn=0 mid-WAIT -> PREADY=0, PRDATA=0, PSLVERR=0; then read 0xFA0 -> 0x0000_0000.
// 2 Full write: WAIT_CYCLES=0, write 0xFA4=0xDEADBEEF with PSTRB=4'hF -> PREADY in the 1st access cycle, PSLVERR=0, wr_pulse=1, wr_index=1; read-back of 0xFA4 -> 0xDEADBEEF.
// 3 Byte strobes: write 0xFA4=0x11223344 with PSTRB=4'b0101 -> read-back 0xDE22BE44.
// 4 Wait states: WAIT_CYCLES=3, read 0xFAC -> PREADY low for 3 access cycles and high on the 4th; PRDATA=0xA5B4_0001.
// 5 Errors: write 0xFAC -> PSLVERR=1, ID unchanged; read 0xFB0 -> PSLVERR=1, PRDATA=0; read 0xFA1 -> PSLVERR=1.
// 6 Back-to-back and abort: write 0xFA0 then read 0xFA0 with no idle cycle -> both complete correctly. With WAIT_CYCLES=2, drop PSEL in WAIT -> no write, FSM returns to IDLE.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB4 bus signals between the PSEL0 master and the register-file completer
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, input PREADY, PRDATA, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB4 completer with byte-strobe RW registers, a read-only ID word and wait states
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0FA0,
  parameter int                    NUM_REGS    = 4,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B4_0001,
  localparam int                   IW          = $clog2(NUM_REGS)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_slave_regfile_if.slave   apb,
  output logic                 wr_pulse,
  output logic [IW-1:0]        wr_index
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t                state, next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];
  logic                  setup, access, cur_wr, err, commit;
  logic [ADDR_WIDTH-1:0] cur_addr, idx_full;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd;
  assign setup  = apb.PSEL & !apb.PENABLE;
  assign access = apb.PSEL & apb.PENABLE;
  // In IDLE the transfer being decoded is the one on the bus; afterwards it is the latched one
  assign cur_addr = state == IDLE ? apb.PADDR : addr_q;
  assign cur_wr   = state == IDLE ? apb.PWRITE : wr_q;
  assign idx_full = (cur_addr - BASE_ADDR) >> 2;
  assign idx      = idx_full[IW-1:0];
  assign err      = |cur_addr[1:0] | (cur_addr < BASE_ADDR) | (idx_full >= ADDR_WIDTH'(NUM_REGS))
                  | (cur_wr & (idx_full == ADDR_WIDTH'(NUM_REGS - 1)));
  assign commit   = state == DONE & wr_q & !err;
  // read mux: the top index falls through to the constant ID word
  always_comb begin
    rd = ID_VALUE;
    for (int i = 0; i < NUM_REGS - 1; i++) if (idx == IW'(i)) rd = regs[i];
  end
  // next state: WAIT leaves early to IDLE whenever the master drops the access phase
  always_comb begin
    next = state == IDLE ? (setup ? (WAIT_CYCLES == 0 ? DONE : WAIT) : IDLE)
         : state == WAIT ? (!access ? IDLE : cnt == 4'd1 ? DONE : WAIT)
         : IDLE;
  end
  // state register, transfer capture and wait-state counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt     <= '0;
    end else begin
      state <= next;
      if (state == IDLE && setup) begin
        addr_q  <= apb.PADDR;
        wr_q    <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
        strb_q  <= apb.PSTRB;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && access) cnt <= cnt - 4'd1;
    end
  end
  // registered response, valid only for the single DONE cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
      apb.PRDATA  <= '0;
      wr_pulse    <= 1'b0;
      wr_index    <= '0;
    end else begin
      apb.PREADY  <= next == DONE;
      apb.PSLVERR <= next == DONE & err;
      apb.PRDATA  <= (next == DONE && !cur_wr && !err) ? rd : '0;
      wr_pulse    <= commit;
      if (commit) wr_index <= idx;
    end
  end
  // byte-lane write commit at the edge that ends DONE
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++)
        for (int k = 0; k < STRB_WIDTH; k++)
          if (commit && idx == IW'(i) && strb_q[k]) regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of three completers (0, 3 and 2 wait states) sharing one master drive
module tb_apb_slave_regfile;
  localparam logic [31:0] ID = 32'hA5B4_0001;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        rdy [3];
  logic        serr [3];
  logic        wp [3];
  logic [31:0] rdat [3];
  logic [1:0]  wi [3];
  int          n_cmp = 0, n_bad = 0;
  always #5 PCLK = ~PCLK;
  apb_slave_regfile_if b[3] ();
  // dut index 0: no wait states, 1: three, 2: two
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign b[g].PSEL    = psel;
    assign b[g].PENABLE = penable;
    assign b[g].PWRITE  = pwrite;
    assign b[g].PADDR   = paddr;
    assign b[g].PWDATA  = pwdata;
    assign b[g].PSTRB   = pstrb;
    assign b[g].PPROT   = 3'b000;
    assign rdy[g]  = b[g].PREADY;
    assign rdat[g] = b[g].PRDATA;
    assign serr[g] = b[g].PSLVERR;
    apb_slave_regfile #(.WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(b[g]), .wr_pulse(wp[g]), .wr_index(wi[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one setup + access transfer; returns after the edge that ends the PREADY cycle
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rd, output logic se, output int waits, output logic pulse, output logic [1:0] widx);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
    @(posedge PCLK); #1 penable = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!rdy[d] && waits < 20) begin
      waits++;
      @(negedge PCLK);
    end
    rd = rdat[d]; se = serr[d];
    @(posedge PCLK); #1;
    pulse = wp[d]; widx = wi[d];
    psel = 1'b0; penable = 1'b0;
  endtask
  task automatic wr_chk(input string tag, input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                        input logic exp_se, input logic exp_pulse, input logic [1:0] exp_idx, input int exp_waits);
    logic [31:0] rd; logic se, pulse; logic [1:0] widx; int waits;
    xfer(d, 1'b1, a, wd, s, rd, se, waits, pulse, widx);
    chk({tag, ".waits"}, waits, exp_waits);
    chk({tag, ".pslverr"}, {31'd0, se}, {31'd0, exp_se});
    chk({tag, ".wr_pulse"}, {31'd0, pulse}, {31'd0, exp_pulse});
    chk({tag, ".wr_index"}, {30'd0, widx}, {30'd0, exp_idx});
  endtask
  task automatic rd_chk(input string tag, input int d, input logic [31:0] a, input logic [31:0] exp_rd,
                        input logic exp_se, input int exp_waits);
    logic [31:0] rd; logic se, pulse; logic [1:0] widx; int waits;
    xfer(d, 1'b0, a, 32'hFFFF_FFFF, 4'hF, rd, se, waits, pulse, widx);
    chk({tag, ".waits"}, waits, exp_waits);
    chk({tag, ".prdata"}, rd, exp_rd);
    chk({tag, ".pslverr"}, {31'd0, se}, {31'd0, exp_se});
    chk({tag, ".wr_pulse"}, {31'd0, pulse}, 32'd0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask
  initial begin
    repeat (3) @(negedge PCLK);
    chk("rst.pready", {31'd0, rdy[0]}, 32'd0);
    chk("rst.prdata", rdat[0], 32'd0);
    chk("rst.pslverr", {31'd0, serr[0]}, 32'd0);
    chk("rst.wr_pulse", {31'd0, wp[0]}, 32'd0);
    chk("rst.wr_index", {30'd0, wi[0]}, 32'd0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    idle(1);
    // reset asserted in the middle of the wait states
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hFAC;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK); PRESETn = 1'b0;
    #1;
    chk("rst_wait.pready", {31'd0, rdy[1]}, 32'd0);
    chk("rst_wait.prdata", rdat[1], 32'd0);
    chk("rst_wait.pslverr", {31'd0, serr[1]}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    idle(1);
    rd_chk("rst_wait.readback", 1, 32'hFA0, 32'h0, 1'b0, 3);
    idle(2);
    // reset asserted while the response is on the bus clears it at once
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hFAC;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK);
    chk("rst_done.pready_before", {31'd0, rdy[0]}, 32'd1);
    chk("rst_done.prdata_before", rdat[0], ID);
    PRESETn = 1'b0;
    #1;
    chk("rst_done.pready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_done.prdata", rdat[0], 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    idle(1);
    rd_chk("rst.reg0", 0, 32'hFA0, 32'h0, 1'b0, 0);
    // full write and byte-strobe writes
    wr_chk("wr_full", 0, 32'hFA4, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 2'd1, 0);
    rd_chk("rd_full", 0, 32'hFA4, 32'hDEAD_BEEF, 1'b0, 0);
    wr_chk("wr_strb", 0, 32'hFA4, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, 2'd1, 0);
    rd_chk("rd_strb", 0, 32'hFA4, 32'hDE22_BE44, 1'b0, 0);
    wr_chk("wr_strb0", 0, 32'hFA4, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1, 2'd1, 0);
    rd_chk("rd_strb0", 0, 32'hFA4, 32'hDE22_BE44, 1'b0, 0);
    // wait states on the ID register
    idle(2);
    rd_chk("wait3.id", 1, 32'hFAC, ID, 1'b0, 3);
    idle(1);
    // error responses
    wr_chk("err.wr_id", 0, 32'hFAC, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 2'd1, 0);
    rd_chk("err.id_kept", 0, 32'hFAC, ID, 1'b0, 0);
    rd_chk("err.rd_range", 0, 32'hFB0, 32'h0, 1'b1, 0);
    rd_chk("err.rd_unalign", 0, 32'hFA1, 32'h0, 1'b1, 0);
    rd_chk("err.rd_below", 0, 32'hF9C, 32'h0, 1'b1, 0);
    wr_chk("err.wr_range", 0, 32'hFB4, 32'h5555_5555, 4'hF, 1'b1, 1'b0, 2'd1, 0);
    // back-to-back write then read with no idle cycle
    wr_chk("b2b.wr", 0, 32'hFA0, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 2'd0, 0);
    rd_chk("b2b.rd", 0, 32'hFA0, 32'h1234_5678, 1'b0, 0);
    rd_chk("b2b.reg2", 0, 32'hFA8, 32'h0, 1'b0, 0);
    // PSEL dropped in WAIT with one wait state left: no commit, back to IDLE
    idle(2);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hFA0; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK);
    chk("abort.pready_a1", {31'd0, rdy[2]}, 32'd0);
    @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    chk("abort.pready_drop", {31'd0, rdy[2]}, 32'd0);
    @(posedge PCLK); #1;
    chk("abort.wr_pulse", {31'd0, wp[2]}, 32'd0);
    chk("abort.pready_after", {31'd0, rdy[2]}, 32'd0);
    rd_chk("abort.reg0", 2, 32'hFA0, 32'h0, 1'b0, 2);
    wr_chk("wait2.wr", 2, 32'hFA8, 32'h0BAD_CAFE, 4'hF, 1'b0, 1'b1, 2'd2, 2);
    rd_chk("wait2.rd", 2, 32'hFA8, 32'h0BAD_CAFE, 1'b0, 2);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
